// File: rtl/bp_gshare_ctrl.sv
// Gshare front-end controller: hashes PC with global history, tracks in-flight branches, trains the table.
// Optional BP_PERF_CNT_EN adds saturating resolve/mispredict counters.
module bp_gshare_ctrl #(
    parameter int IDX_W = 8,
    parameter int GHR_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pred_req,
    input  logic [31:0]                pred_pc,
    output logic                       pred_ready,
    output logic                       pred_valid,
    output logic                       pred_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                       underflow,
    output logic                       get,
    output logic [IDX_W-1:0]           get_index,
    input  logic                       prediction,
    output logic                       set,
    output logic [IDX_W-1:0]           set_index,
    output logic                       feedback,
    output logic [15:0]                perf_preds,
    output logic [15:0]                perf_miss
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

    state_t             r_state, w_state_nxt;
    logic [GHR_W-1:0]   r_ghr, w_ghr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic               r_get, r_set, r_feedback;
    logic [IDX_W-1:0]   r_get_index, r_set_index;
    logic               r_pred_valid, r_pred_taken, r_mispredict, r_underflow, r_pred_ready;

    logic [IDX_W-1:0]   r_q_idx  [DEPTH];
    logic               r_q_pred [DEPTH];
    logic [GHR_W-1:0]   r_q_ghr  [DEPTH];

    logic [IDX_W-1:0]   w_head_idx, w_hash;
    logic               w_head_pred;
    logic [GHR_W-1:0]   w_head_ghr;
    logic               w_pop, w_miss, w_push, w_accept;
    logic               w_unused;

    assign w_head_idx  = r_q_idx[r_rptr];
    assign w_head_pred = r_q_pred[r_rptr];
    assign w_head_ghr  = r_q_ghr[r_rptr];

    assign w_pop    = res_valid && (r_cnt != '0);
    assign w_miss   = w_pop && (res_taken != w_head_pred);
    assign w_push   = (r_state == S_CAPTURE) && !w_miss;
    assign w_accept = (r_state == S_IDLE) && r_pred_ready && pred_req;

    // A lookup accepted on a flush edge hashes with the already-repaired history.
    assign w_hash   = pred_pc[IDX_W+1:2] ^ IDX_W'(w_ghr_nxt);
    assign w_unused = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], w_head_ghr[GHR_W-1]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_miss && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_ghr_nxt = r_ghr;
        if (w_miss)
            w_ghr_nxt = {w_head_ghr[GHR_W-2:0], res_taken};
        else if (w_push)
            w_ghr_nxt = {r_ghr[GHR_W-2:0], prediction};
        w_cnt_nxt = w_miss ? '0 : (r_cnt + CNT_W'(w_push) - CNT_W'(w_pop));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ghr        <= '0;
            r_cnt        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_get        <= 1'b0;
            r_get_index  <= '0;
            r_set        <= 1'b0;
            r_set_index  <= '0;
            r_feedback   <= 1'b0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_mispredict <= 1'b0;
            r_underflow  <= 1'b0;
            r_pred_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_ghr        <= w_ghr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_get        <= w_accept;
            r_set        <= w_pop;
            r_mispredict <= w_miss;
            r_pred_valid <= w_push;
            r_pred_ready <= (w_state_nxt == S_IDLE) && (w_cnt_nxt < DEPTH_C);
            if (w_accept) r_get_index <= w_hash;
            if (w_push) r_pred_taken <= prediction;
            if (w_pop) begin
                r_set_index <= w_head_idx;
                r_feedback  <= res_taken;
            end
            if (res_valid && (r_cnt == '0)) r_underflow <= 1'b1;
            if (w_miss) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Entry payload carries no reset; occupancy alone marks it valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wptr]  <= r_get_index;
            r_q_pred[r_wptr] <= prediction;
            r_q_ghr[r_wptr]  <= r_ghr;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [15:0] r_perf_preds, r_perf_miss;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_preds <= '0;
            r_perf_miss  <= '0;
        end else begin
            if (w_pop)  r_perf_preds <= sat_inc(r_perf_preds);
            if (w_miss) r_perf_miss  <= sat_inc(r_perf_miss);
        end
    end

    assign perf_preds = r_perf_preds;
    assign perf_miss  = r_perf_miss;
`else
    assign perf_preds = 16'd0;
    assign perf_miss  = 16'd0;
`endif

    assign pred_ready = r_pred_ready;
    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign mispredict = r_mispredict;
    assign inflight   = r_cnt;
    assign underflow  = r_underflow;
    assign get        = r_get;
    assign get_index  = r_get_index;
    assign set        = r_set;
    assign set_index  = r_set_index;
    assign feedback   = r_feedback;

endmodule

// File: tb/tb_bp_gshare_ctrl.sv
// Directed-vector bench for bp_gshare_ctrl (default parameters IDX_W=8, GHR_W=8, DEPTH=4).
module tb_bp_gshare_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_ready, pred_valid, pred_taken;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        mispredict, underflow, get, set, feedback;
    logic [2:0]  inflight;
    logic [7:0]  get_index, set_index;
    logic        prediction = 1'b0;
    logic [15:0] perf_preds, perf_miss;

    int n_vec = 0;
    int n_err = 0;

    bp_gshare_ctrl #(.IDX_W(8), .GHR_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_ready(pred_ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
        .inflight(inflight), .underflow(underflow), .get(get), .get_index(get_index),
        .prediction(prediction), .set(set), .set_index(set_index), .feedback(feedback),
        .perf_preds(perf_preds), .perf_miss(perf_miss)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] pc, input logic p);
        pred_req   = 1'b1;
        pred_pc    = pc;
        prediction = p;
        tick();
        pred_req   = 1'b0;
    endtask

    task automatic apply_reset();
        pred_req  = 1'b0;
        res_valid = 1'b0;
        reset_n   = 1'b0;
        repeat (3) tick();
        reset_n   = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_vec++; if (get !== 1'b0 || set !== 1'b0) begin n_err++; $display("FAIL reset_strobes: get=%b set=%b want 0 0", get, set); end
        n_vec++; if (get_index !== 8'h00 || set_index !== 8'h00 || feedback !== 1'b0) begin n_err++; $display("FAIL reset_idx: gi=%h si=%h fb=%b want 00 00 0", get_index, set_index, feedback); end
        n_vec++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || mispredict !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: pv=%b pt=%b mp=%b uf=%b want 0000", pred_valid, pred_taken, mispredict, underflow); end
        n_vec++; if (inflight !== 3'd0 || pred_ready !== 1'b1) begin n_err++; $display("FAIL reset_queue: inflight=%0d ready=%b want 0 1", inflight, pred_ready); end
        reset_n = 1'b1;
        tick();
        n_vec++; if (pred_ready !== 1'b1 || get !== 1'b0) begin n_err++; $display("FAIL post_reset: ready=%b get=%b want 1 0", pred_ready, get); end
    endtask

    task automatic test_first_pred();
        accept(32'h10, 1'b1);
        n_vec++; if (get !== 1'b1 || get_index !== 8'h04) begin n_err++; $display("FAIL first_get: get=%b idx=%h want 1 04", get, get_index); end
        n_vec++; if (pred_ready !== 1'b0 || pred_valid !== 1'b0) begin n_err++; $display("FAIL first_issue: ready=%b pv=%b want 0 0", pred_ready, pred_valid); end
        tick();
        n_vec++; if (get !== 1'b0 || pred_valid !== 1'b0) begin n_err++; $display("FAIL first_capture: get=%b pv=%b want 0 0", get, pred_valid); end
        tick();
        n_vec++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || inflight !== 3'd1) begin n_err++; $display("FAIL first_valid: pv=%b pt=%b inflight=%0d want 1 1 1", pred_valid, pred_taken, inflight); end
        tick();
        n_vec++; if (pred_valid !== 1'b0 || pred_ready !== 1'b1) begin n_err++; $display("FAIL first_pulse: pv=%b ready=%b want 0 1", pred_valid, pred_ready); end
    endtask

    task automatic test_ghr_hash();
        accept(32'h10, 1'b1);
        n_vec++; if (get_index !== 8'h05) begin n_err++; $display("FAIL ghr_hash: idx=%h want 05", get_index); end
        repeat (2) tick();
        n_vec++; if (inflight !== 3'd2 || pred_valid !== 1'b1) begin n_err++; $display("FAIL ghr_push: inflight=%0d pv=%b want 2 1", inflight, pred_valid); end
    endtask

    task automatic test_full();
        accept(32'h20, 1'b0);
        n_vec++; if (get_index !== 8'h0B) begin n_err++; $display("FAIL full_idx3: idx=%h want 0b", get_index); end
        repeat (2) tick();
        n_vec++; if (pred_taken !== 1'b0 || pred_valid !== 1'b1) begin n_err++; $display("FAIL full_pred3: pt=%b pv=%b want 0 1", pred_taken, pred_valid); end
        accept(32'h30, 1'b0);
        n_vec++; if (get_index !== 8'h0A) begin n_err++; $display("FAIL full_idx4: idx=%h want 0a", get_index); end
        repeat (2) tick();
        n_vec++; if (inflight !== 3'd4 || pred_ready !== 1'b0) begin n_err++; $display("FAIL full_state: inflight=%0d ready=%b want 4 0", inflight, pred_ready); end
        pred_req = 1'b1;
        pred_pc  = 32'h50;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (get !== 1'b0 || inflight !== 3'd4) begin n_err++; $display("FAIL full_block%0d: get=%b inflight=%0d want 0 4", i, get, inflight); end
        end
        pred_req = 1'b0;
    endtask

    task automatic test_resolve_correct();
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        n_vec++; if (set !== 1'b1 || set_index !== 8'h04 || feedback !== 1'b1) begin n_err++; $display("FAIL res_set: set=%b si=%h fb=%b want 1 04 1", set, set_index, feedback); end
        n_vec++; if (mispredict !== 1'b0 || inflight !== 3'd3) begin n_err++; $display("FAIL res_state: mp=%b inflight=%0d want 0 3", mispredict, inflight); end
        tick();
        n_vec++; if (set !== 1'b0 || pred_ready !== 1'b1) begin n_err++; $display("FAIL res_pulse: set=%b ready=%b want 0 1", set, pred_ready); end
    endtask

    task automatic test_back_to_back();
        // GHR is 0x0C here; PC 0x40 hashes to 0x10 ^ 0x0C.
        accept(32'h40, 1'b1);
        n_vec++; if (get_index !== 8'h1C) begin n_err++; $display("FAIL b2b_idx: idx=%h want 1c", get_index); end
        tick();
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        n_vec++; if (pred_valid !== 1'b1 || set !== 1'b1 || set_index !== 8'h05) begin n_err++; $display("FAIL b2b_both: pv=%b set=%b si=%h want 1 1 05", pred_valid, set, set_index); end
        n_vec++; if (inflight !== 3'd3 || mispredict !== 1'b0) begin n_err++; $display("FAIL b2b_count: inflight=%0d mp=%b want 3 0", inflight, mispredict); end
    endtask

    task automatic test_mispredict_flush();
        accept(32'h00, 1'b0);
        n_vec++; if (get_index !== 8'h19) begin n_err++; $display("FAIL flush_specghr: idx=%h want 19", get_index); end
        tick();
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        n_vec++; if (mispredict !== 1'b1 || set !== 1'b1 || set_index !== 8'h0B || feedback !== 1'b1) begin n_err++; $display("FAIL flush_resolve: mp=%b set=%b si=%h fb=%b want 1 1 0b 1", mispredict, set, set_index, feedback); end
        n_vec++; if (inflight !== 3'd0 || pred_valid !== 1'b0 || pred_ready !== 1'b1) begin n_err++; $display("FAIL flush_queue: inflight=%0d pv=%b ready=%b want 0 0 1", inflight, pred_valid, pred_ready); end
        tick();
        n_vec++; if (mispredict !== 1'b0 || pred_valid !== 1'b0) begin n_err++; $display("FAIL flush_pulse: mp=%b pv=%b want 0 0", mispredict, pred_valid); end
        accept(32'h00, 1'b0);
        n_vec++; if (get_index !== 8'h07) begin n_err++; $display("FAIL flush_ghr: idx=%h want 07", get_index); end
        repeat (2) tick();
        n_vec++; if (inflight !== 3'd1) begin n_err++; $display("FAIL flush_refill: inflight=%0d want 1", inflight); end
    endtask

    task automatic test_spec_mispredict();
        accept(32'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        n_vec++; if (get !== 1'b0 || inflight !== 3'd0 || get_index !== 8'h00) begin n_err++; $display("FAIL async_reset: get=%b inflight=%0d idx=%h want 0 0 00", get, inflight, get_index); end
        apply_reset();
        repeat (3) begin
            tick();
            n_vec++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL dropped_lookup: pv=%b want 0", pred_valid); end
        end
        accept(32'h10, 1'b1);
        repeat (2) tick();
        accept(32'h10, 1'b1);
        n_vec++; if (get_index !== 8'h05) begin n_err++; $display("FAIL spec_idx2: idx=%h want 05", get_index); end
        tick();
        res_valid = 1'b1;
        res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        n_vec++; if (mispredict !== 1'b1 || inflight !== 3'd0 || pred_valid !== 1'b0) begin n_err++; $display("FAIL spec_mp: mp=%b inflight=%0d pv=%b want 1 0 0", mispredict, inflight, pred_valid); end
        n_vec++; if (set !== 1'b1 || set_index !== 8'h04 || feedback !== 1'b0) begin n_err++; $display("FAIL spec_set: set=%b si=%h fb=%b want 1 04 0", set, set_index, feedback); end
        tick();
        accept(32'h10, 1'b1);
        n_vec++; if (get_index !== 8'h04) begin n_err++; $display("FAIL spec_ghr: idx=%h want 04", get_index); end
        repeat (2) tick();
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        n_vec++; if (mispredict !== 1'b0 || inflight !== 3'd0 || set !== 1'b1) begin n_err++; $display("FAIL spec_drain: mp=%b inflight=%0d set=%b want 0 0 1", mispredict, inflight, set); end
    endtask

    task automatic test_underflow();
        tick();
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_pre: uf=%b want 0", underflow); end
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        n_vec++; if (set !== 1'b0 || underflow !== 1'b1 || inflight !== 3'd0) begin n_err++; $display("FAIL uf_event: set=%b uf=%b inflight=%0d want 0 1 0", set, underflow, inflight); end
        tick();
        n_vec++; if (underflow !== 1'b1 || mispredict !== 1'b0) begin n_err++; $display("FAIL uf_sticky: uf=%b mp=%b want 1 0", underflow, mispredict); end
`ifdef BP_PERF_CNT_EN
        n_vec++; if (perf_preds !== 16'd2 || perf_miss !== 16'd1) begin n_err++; $display("FAIL perf: preds=%0d miss=%0d want 2 1", perf_preds, perf_miss); end
`else
        n_vec++; if (perf_preds !== 16'd0 || perf_miss !== 16'd0) begin n_err++; $display("FAIL perf_tied: preds=%0d miss=%0d want 0 0", perf_preds, perf_miss); end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_first_pred();
        test_ghr_hash();
        test_full();
        test_resolve_correct();
        test_back_to_back();
        test_mispredict_flush();
        test_spec_mispredict();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
